// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Brief    : Loadable down-counter with valid/ready load and expiry
//             handshakes, enable gating, optional auto-reload and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int  MAX_NUM = 100,
    localparam int CW      = $clog2(MAX_NUM + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [CW-1:0] load_value,
    input  logic          reload,
    input  logic          en,
    input  logic          abort,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done_valid,
    input  logic          done_ready,
    output logic          zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_MAX_VAL = CW'(MAX_NUM);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_reload;
    logic [CW-1:0] w_load_clamped;

    // Out-of-range start values saturate at the largest loadable count
    assign w_load_clamped = (load_value > c_MAX_VAL) ? c_MAX_VAL : load_value;

    // State, count and reload register; abort overrides every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
        end else if (abort) begin
            // Reload register intentionally survives an abort
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_count  <= w_load_clamped;
                        r_reload <= w_load_clamped;
                        r_state  <= (w_load_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        // count <= 1 also covers a count of 0 so it can never wrap
                        if (r_count <= c_ONE) begin
                            r_count <= '0;
                            r_state <= DONE;
                        end else begin
                            r_count <= r_count - c_ONE;
                        end
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        if (reload) begin
                            r_count <= r_reload;
                            r_state <= (r_reload == '0) ? DONE : RUN;
                        end else begin
                            r_count <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state == RUN);
    assign done_valid = (r_state == DONE);
    assign count      = r_count;
    assign zero       = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_timer
//  Brief    : Directed self-checking bench for countdown_timer with a
//             cycle-level reference model and literal anchor checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int MAX_NUM = 100;
    localparam int CW      = $clog2(MAX_NUM + 1);

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          load_valid = 1'b0;
    logic [CW-1:0] load_value = '0;
    logic          reload     = 1'b0;
    logic          en         = 1'b0;
    logic          abort      = 1'b0;
    logic          done_ready = 1'b0;
    logic          load_ready;
    logic          busy;
    logic          done_valid;
    logic          zero;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: "phase" is what the timer is doing, not an encoding
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2;
    int m_phase = PH_IDLE;
    int m_cnt   = 0;
    int m_rl    = 0;

    bit en_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    countdown_timer #(.MAX_NUM(MAX_NUM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .reload     (reload),
        .en         (en),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > MAX_NUM) ? MAX_NUM : v;
    endfunction

    // Model advances on the same events as the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= PH_IDLE;
            m_cnt   <= 0;
            m_rl    <= 0;
        end else if (abort) begin
            m_phase <= PH_IDLE;
            m_cnt   <= 0;
        end else if (m_phase == PH_IDLE) begin
            if (load_valid) begin
                m_cnt   <= clampv(int'(load_value));
                m_rl    <= clampv(int'(load_value));
                m_phase <= (clampv(int'(load_value)) == 0) ? PH_DONE : PH_RUN;
            end
        end else if (m_phase == PH_RUN) begin
            if (en) begin
                m_cnt   <= m_cnt - 1;
                m_phase <= (m_cnt == 1) ? PH_DONE : PH_RUN;
            end
        end else begin
            if (done_ready) begin
                m_cnt   <= reload ? m_rl : 0;
                m_phase <= !reload ? PH_IDLE : ((m_rl == 0) ? PH_DONE : PH_RUN);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count",      int'(count),      m_cnt);
            check("m_load_ready", int'(load_ready), int'(m_phase == PH_IDLE));
            check("m_busy",       int'(busy),       int'(m_phase == PH_RUN));
            check("m_done_valid", int'(done_valid), int'(m_phase == PH_DONE));
            check("m_zero",       int'(zero),       int'(m_cnt == 0));
        end
    end

    initial begin
        int first_seen;
        int last_rise;
        int n_rise;

        // Reset state
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_busy",       int'(busy),       0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_zero",       int'(zero),       1);
        check("rst_count",      int'(count),      0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic countdown from 5, expiry left pending
        load_valid = 1'b1; load_value = 7'd5; en = 1'b1; done_ready = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        check("s1_count_load", int'(count), 5);
        check("s1_busy_load",  int'(busy),  1);
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            check("s1_count", int'(count), k);
            check("s1_done",  int'(done_valid), int'(k == 0));
        end
        repeat (2) begin
            @(negedge clk);
            check("s1_done_hold", int'(done_valid), 1);
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("s1_idle", int'(load_ready), 1);

        // Clamping: 127 is the largest drivable value at this width
        load_valid = 1'b1; load_value = 7'd127; en = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        check("s2_clamp", int'(count), 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s2_abort_count", int'(count), 0);
        // Zero load goes straight to DONE
        load_valid = 1'b1; load_value = 7'd0;
        @(negedge clk);
        load_valid = 1'b0;
        check("s2_zero_done", int'(done_valid), 1);
        check("s2_zero_busy", int'(busy),       0);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("s2_idle", int'(load_ready), 1);

        // Enable gating: load 3 with en 1,0,0,1,1
        load_valid = 1'b1; load_value = 7'd3;
        @(negedge clk);
        load_valid = 1'b0;
        first_seen = -1;
        for (int i = 0; i < 8; i++) begin
            en = (i < 5) ? en_pat[i] : 1'b1;
            @(negedge clk);
            if (done_valid && first_seen < 0) first_seen = i + 1;
        end
        check("s3_first_done", first_seen, 5);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;

        // Auto-reload: done pulses every 3 cycles
        load_valid = 1'b1; load_value = 7'd2; reload = 1'b1; done_ready = 1'b1; en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        last_rise = -1;
        n_rise    = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (done_valid) begin
                if (last_rise >= 0) check("s4_period", i - last_rise, 3);
                last_rise = i;
                n_rise++;
            end
        end
        check("s4_n_rise", n_rise, 3);
        reload = 1'b0;
        for (int t = 0; t < 6 && !load_ready; t++) @(negedge clk);
        check("s4_back_idle", int'(load_ready), 1);
        done_ready = 1'b0;

        // Abort in RUN at count 2
        load_valid = 1'b1; load_value = 7'd5; en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int t = 0; t < 10 && count != 7'd2; t++) @(negedge clk);
        check("s5_reach2", int'(count), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s5_abort_idle",  int'(load_ready), 1);
        check("s5_abort_count", int'(count),      0);
        check("s5_abort_done",  int'(done_valid), 0);
        repeat (4) @(negedge clk);
        check("s5_no_done", int'(done_valid), 0);
        // Abort beats the reload handshake in DONE
        load_valid = 1'b1; load_value = 7'd1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        check("s5_in_done", int'(done_valid), 1);
        abort = 1'b1; done_ready = 1'b1; reload = 1'b1;
        @(negedge clk);
        abort = 1'b0; done_ready = 1'b0; reload = 1'b0;
        check("s5_abort_idle2", int'(load_ready), 1);
        check("s5_abort_busy2", int'(busy),       0);

        // Asynchronous reset mid-RUN
        load_valid = 1'b1; load_value = 7'd6; en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int t = 0; t < 10 && count != 7'd4; t++) @(negedge clk);
        check("s6_reach4", int'(count), 4);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_count", int'(count),      0);
        check("s6_rst_ready", int'(load_ready), 1);
        check("s6_rst_zero",  int'(zero),       1);
        @(negedge clk);
        rst_n = 1'b1;
        load_valid = 1'b1; load_value = 7'd1;
        @(negedge clk);
        load_valid = 1'b0;
        check("s6_count1", int'(count), 1);
        check("s6_nodone", int'(done_valid), 0);
        @(negedge clk);
        check("s6_done", int'(done_valid), 1);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
